// File: rtl/fetch_ctrl_if.sv
// Instruction-memory port of the fetch stage: request/grant plus read-data return.
// The master side is the fetch controller; the slave side is the instruction memory.
interface fetch_ctrl_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr_F;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr_F,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr_F,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one instruction-memory request at a time
// and hands fetched words to decode through a one-entry skid buffer.
module fetch_ctrl #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCSrc_F,
    input  logic [ADDR_W-1:0]  PCBranch_F,
    input  logic               stall_D,
    fetch_ctrl_if.master       imem,
    output logic               instr_valid_D,
    output logic [INSTR_W-1:0] instr_D,
    output logic [ADDR_W-1:0]  pc_D,
    output logic [1:0]         state_dbg_o
);
    // Handshakes: a request is accepted on a posedge where imem_req && imem_gnt; its data
    // returns on a later posedge with imem_rvalid (only honoured in S_WAIT). Decode takes
    // instr_D on a posedge where instr_valid_D && !stall_D.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               kill_q, kill_d;
    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;

    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  branch_pc;
    logic [ADDR_W-1:0]  reset_pc;

    assign pc_inc    = pc_q + ADDR_W'(4);
    assign branch_pc = PCBranch_F & ~ADDR_W'(3);
    assign reset_pc  = RESET_PC & ~ADDR_W'(3);

    assign imem.imem_req    = (state_q == S_REQ);
    assign imem.imem_addr_F = pc_q;
    assign instr_valid_D    = valid_q;
    assign instr_D          = instr_q;
    assign pc_D             = pc_out_q;
    assign state_dbg_o      = state_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;

        // Decode drains the output register; a load below re-fills it in the same cycle.
        if (valid_q && !stall_D) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem.imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (!valid_q || !stall_D) begin
                        instr_d  = imem.imem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_inc;
                        state_d  = S_REQ;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem.imem_rdata;
                        skid_pc_d    = pc_q;
                        pc_d         = pc_inc;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_D && skid_valid_q) begin
                    instr_d      = skid_instr_q;
                    pc_out_d     = skid_pc_q;
                    valid_d      = 1'b1;
                    skid_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect overrides everything above; an accepted or in-flight request is killed.
        if (PCSrc_F) begin
            pc_d         = branch_pc;
            valid_d      = 1'b0;
            instr_d      = instr_q;
            pc_out_d     = pc_out_q;
            skid_valid_d = 1'b0;
            skid_instr_d = skid_instr_q;
            skid_pc_d    = skid_pc_q;
            kill_d       = kill_q;
            unique case (state_q)
                S_REQ: begin
                    if (imem.imem_gnt) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= reset_pc;
            kill_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            pc_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: memory model with random grant/latency, directed scenarios,
// then random redirects, stalls and resets checked against an in-order scoreboard.
module tb_fetch_ctrl;
    localparam int              ADDR_W   = 64;
    localparam int              INSTR_W  = 32;
    localparam logic [63:0]     RESET_PC = 64'h0;

    logic               clk = 1'b0;
    logic               reset;
    logic               PCSrc_F;
    logic [ADDR_W-1:0]  PCBranch_F;
    logic               stall_D;
    logic               instr_valid_D;
    logic [INSTR_W-1:0] instr_D;
    logic [ADDR_W-1:0]  pc_D;
    logic [1:0]         dbg_state;

    fetch_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) mif ();

    fetch_ctrl #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .PCSrc_F       (PCSrc_F),
        .PCBranch_F    (PCBranch_F),
        .stall_D       (stall_D),
        .imem          (mif),
        .instr_valid_D (instr_valid_D),
        .instr_D       (instr_D),
        .pc_D          (pc_D),
        .state_dbg_o   (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: addresses accepted by memory and still alive, in delivery order.
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] next_req;
    bit                pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    int                pend_cnt;
    bit                exp_rst, exp_flush, exp_hold;
    logic [INSTR_W-1:0] held_instr;
    logic [ADDR_W-1:0]  held_pc;
    int                idle;
    int                gnt_pct, lat_min, lat_max, spur_pct;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'hC0DE_5A5A;
    endfunction

    function automatic logic [63:0] pick_target();
        logic [63:0] t;
        case ($urandom_range(3))
            0: t = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(15));
            1: t = {$urandom, $urandom};
            2: t = 64'hAAAA_BBBB_CCCC_DDDD;
            default: t = {32'h0, 32'($urandom_range(255))};
        endcase
        return t;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, predict the coming posedge, then check its results at negedge.
    task automatic step(input bit rst_n, input bit stall, input bit redir, input logic [63:0] tgt);
        bit acc, cons;
        logic [ADDR_W-1:0] exp_pc;
        reset      = rst_n;
        stall_D    = stall;
        PCSrc_F    = redir;
        PCBranch_F = tgt;
        mif.imem_gnt = ($urandom_range(99) < gnt_pct);
        if (pend_valid && pend_cnt == 0) begin
            mif.imem_rvalid = 1'b1;
            mif.imem_rdata  = mem_word(pend_addr);
        end else if (!pend_valid && $urandom_range(99) < spur_pct) begin
            mif.imem_rvalid = 1'b1;
            mif.imem_rdata  = $urandom;
        end else begin
            mif.imem_rvalid = 1'b0;
            mif.imem_rdata  = $urandom;
        end
        #1;
        if (!rst_n) begin
            exp_rst    = 1'b1;
            next_req   = RESET_PC;
            pend_valid = 1'b0;
            idle       = 0;
            exp_q.delete();
        end else begin
            acc  = mif.imem_req && mif.imem_gnt;
            cons = instr_valid_D && !stall && !redir;
            if (mif.imem_req) check_eq("one_outstanding", pend_valid, 1'b0);
            if (acc) check_eq("req_addr", mif.imem_addr_F, next_req);
            if (cons) begin
                exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : ~pc_D;
                check_eq("deliver_pc", pc_D, exp_pc);
                check_eq("deliver_instr", instr_D, mem_word(exp_pc));
            end
            if (mif.imem_rvalid && pend_valid) pend_valid = 1'b0;
            else if (pend_valid) pend_cnt--;
            if (acc) begin
                exp_q.push_back(next_req);
                pend_valid = 1'b1;
                pend_addr  = mif.imem_addr_F;
                pend_cnt   = $urandom_range(lat_max, lat_min);
                next_req   = next_req + 64'd4;
            end
            if (redir) begin
                exp_flush = 1'b1;
                exp_q.delete();
                next_req  = tgt & ~64'd3;
            end else if (stall && instr_valid_D) begin
                exp_hold   = 1'b1;
                held_instr = instr_D;
                held_pc    = pc_D;
            end
            if (acc || cons) idle = 0;
            else idle++;
            if (idle >= 300) begin
                check_eq("progress", idle, 0);
                idle = 0;
            end
        end
        @(negedge clk);
        if (exp_rst) begin
            check_eq("rst_req", mif.imem_req, 1'b0);
            check_eq("rst_addr", mif.imem_addr_F, RESET_PC);
            check_eq("rst_valid", instr_valid_D, 1'b0);
            check_eq("rst_instr", instr_D, 0);
            check_eq("rst_pc_d", pc_D, 0);
        end else if (exp_flush) begin
            check_eq("flush_valid", instr_valid_D, 1'b0);
        end else if (exp_hold) begin
            check_eq("stall_hold", {instr_valid_D, instr_D, pc_D}, {1'b1, held_instr, held_pc});
        end
        exp_rst   = 1'b0;
        exp_flush = 1'b0;
        exp_hold  = 1'b0;
    endtask

    task automatic run_until_valid(input string tag);
        int n;
        n = 0;
        while (!instr_valid_D && n < 40) begin
            step(1'b1, 1'b0, 1'b0, 64'h0);
            n++;
        end
        check_eq({tag, "_valid"}, instr_valid_D, 1'b1);
    endtask

    task automatic run_until_pending(input string tag);
        int n;
        n = 0;
        while (!pend_valid && n < 40) begin
            step(1'b1, 1'b0, 1'b0, 64'h0);
            n++;
        end
        check_eq({tag, "_pending"}, pend_valid, 1'b1);
    endtask

    initial begin
        reset = 1'b0; stall_D = 1'b0; PCSrc_F = 1'b0; PCBranch_F = '0;
        mif.imem_gnt = 1'b0; mif.imem_rvalid = 1'b0; mif.imem_rdata = '0;
        next_req = RESET_PC; pend_valid = 1'b0; pend_addr = '0; pend_cnt = 0;
        exp_rst = 1'b0; exp_flush = 1'b0; exp_hold = 1'b0; idle = 0;
        held_instr = '0; held_pc = '0;
        gnt_pct = 100; lat_min = 0; lat_max = 0; spur_pct = 0;
        @(negedge clk);

        // Reset, then a straight-line stream from RESET_PC.
        repeat (5) step(1'b0, 1'b0, 1'b0, 64'h0);
        repeat (12) step(1'b1, 1'b0, 1'b0, 64'h0);

        // Decode stall: output held, one word skidded, no request while holding.
        step(1'b0, 1'b0, 1'b0, 64'h0);
        run_until_valid("t2");
        check_eq("t2_first_pc", pc_D, RESET_PC);
        repeat (4) step(1'b1, 1'b1, 1'b0, 64'h0);
        check_eq("t2_hold_req", mif.imem_req, 1'b0);
        check_eq("t2_hold_pc", pc_D, RESET_PC);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check_eq("t2_skid_valid", instr_valid_D, 1'b1);
        check_eq("t2_skid_pc", pc_D, RESET_PC + 64'd4);

        // Redirect while waiting for data: response dropped, target delivered.
        lat_min = 2; lat_max = 2;
        pend_valid = pend_valid;
        run_until_pending("t3");
        step(1'b1, 1'b0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
        run_until_valid("t3");
        check_eq("t3_pc", pc_D, 64'hAAAA_BBBB_CCCC_DDDC);
        check_eq("t3_instr", instr_D, mem_word(64'hAAAA_BBBB_CCCC_DDDC));

        // Redirect while stalled in the skid state.
        lat_min = 0; lat_max = 0;
        run_until_valid("t4a");
        repeat (6) step(1'b1, 1'b1, 1'b0, 64'h0);
        check_eq("t4_hold_req", mif.imem_req, 1'b0);
        step(1'b1, 1'b1, 1'b1, 64'h0000_1234_5678_9AB3);
        run_until_valid("t4b");
        check_eq("t4_pc", pc_D, 64'h0000_1234_5678_9AB0);

        // Redirect to the top of the address space, PC wraps to 0.
        step(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_until_valid("t5a");
        check_eq("t5_top_pc", pc_D, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        run_until_valid("t5b");
        check_eq("t5_wrap_pc", pc_D, 64'h0);

        // Reset pulse in the cycle the response arrives.
        run_until_pending("t6");
        step(1'b0, 1'b0, 1'b0, 64'h0);
        run_until_valid("t6");
        check_eq("t6_pc", pc_D, RESET_PC);
        check_eq("t6_instr", instr_D, mem_word(RESET_PC));

        // Random traffic.
        gnt_pct = 70; lat_min = 0; lat_max = 3; spur_pct = 10;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(999) >= 3), ($urandom_range(99) < 30),
                 ($urandom_range(99) < 5), pick_target());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
